// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands/control, supports stall and flush,
// and presents final ALU operands. Define FWD_EN to enable EX/MEM and MEM/WB forwarding.
module id_ex_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        valid_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    input  logic [31:0] imm_i,
    input  logic [2:0]  ALUCtrl_i,
    input  logic        ALUSrc_i,
    input  logic        RegDst_i,
    input  logic        RegWrite_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        MemtoReg_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic        exmem_RegWrite_i,
    input  logic        memwb_RegWrite_i,
    input  logic [4:0]  exmem_rd_i,
    input  logic [4:0]  memwb_rd_i,
    input  logic [31:0] exmem_data_i,
    input  logic [31:0] memwb_data_i,
    output logic        valid_o,
    output logic [31:0] data1_o,
    output logic [31:0] data2_o,
    output logic [31:0] store_data_o,
    output logic [2:0]  ALUCtrl_o,
    output logic        RegWrite_o,
    output logic        MemRead_o,
    output logic        MemWrite_o,
    output logic        MemtoReg_o,
    output logic [4:0]  wreg_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o
);

    logic        valid_q, valid_d;
    logic [31:0] data1_q, data1_d;
    logic [31:0] data2_q, data2_d;
    logic [31:0] imm_q, imm_d;
    logic [2:0]  alu_ctrl_q, alu_ctrl_d;
    logic        alu_src_q, alu_src_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic [4:0]  rs_q, rs_d;
    logic [4:0]  rt_q, rt_d;
    logic [4:0]  wreg_q, wreg_d;

    always_comb begin
        valid_d      = valid_q;
        data1_d      = data1_q;
        data2_d      = data2_q;
        imm_d        = imm_q;
        alu_ctrl_d   = alu_ctrl_q;
        alu_src_d    = alu_src_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        wreg_d       = wreg_q;
        if (flush_i) begin
            valid_d      = 1'b0;
            data1_d      = '0;
            data2_d      = '0;
            imm_d        = '0;
            alu_ctrl_d   = '0;
            alu_src_d    = 1'b0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            rs_d         = '0;
            rt_d         = '0;
            wreg_d       = '0;
        end else if (!stall_i) begin
            valid_d      = valid_i;
            data1_d      = data1_i;
            data2_d      = data2_i;
            imm_d        = imm_i;
            alu_ctrl_d   = ALUCtrl_i;
            alu_src_d    = ALUSrc_i;
            // An invalid decode slot enters as a bubble: no side effects downstream.
            reg_write_d  = valid_i & RegWrite_i;
            mem_read_d   = valid_i & MemRead_i;
            mem_write_d  = valid_i & MemWrite_i;
            mem_to_reg_d = valid_i & MemtoReg_i;
            rs_d         = rs_i;
            rt_d         = rt_i;
            wreg_d       = RegDst_i ? rd_i : rt_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q      <= 1'b0;
            data1_q      <= '0;
            data2_q      <= '0;
            imm_q        <= '0;
            alu_ctrl_q   <= '0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            rs_q         <= '0;
            rt_q         <= '0;
            wreg_q       <= '0;
        end else begin
            valid_q      <= valid_d;
            data1_q      <= data1_d;
            data2_q      <= data2_d;
            imm_q        <= imm_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_src_q    <= alu_src_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            wreg_q       <= wreg_d;
        end
    end

    logic [31:0] op1;
    logic [31:0] rt_val;

`ifdef FWD_EN
    // EX/MEM is the younger producer, so it takes priority; r0 is never forwarded.
    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] val);
        if (exmem_RegWrite_i && exmem_rd_i == idx && idx != 5'd0) return exmem_data_i;
        if (memwb_RegWrite_i && memwb_rd_i == idx && idx != 5'd0) return memwb_data_i;
        return val;
    endfunction

    assign op1    = fwd(rs_q, data1_q);
    assign rt_val = fwd(rt_q, data2_q);
`else
    logic unused_fwd;
    assign unused_fwd = ^{exmem_RegWrite_i, memwb_RegWrite_i, exmem_rd_i, memwb_rd_i,
                          exmem_data_i, memwb_data_i};
    assign op1    = data1_q;
    assign rt_val = data2_q;
`endif

    assign valid_o      = valid_q;
    assign data1_o      = op1;
    assign data2_o      = alu_src_q ? imm_q : rt_val;
    assign store_data_o = rt_val;
    assign ALUCtrl_o    = alu_ctrl_q;
    assign RegWrite_o   = reg_write_q;
    assign MemRead_o    = mem_read_q;
    assign MemWrite_o   = mem_write_q;
    assign MemtoReg_o   = mem_to_reg_q;
    assign wreg_o       = wreg_q;
    assign rs_o         = rs_q;
    assign rt_o         = rt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; expectations follow FWD_EN when it is defined.
module tb_id_ex_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, stall_i, flush_i, valid_i;
    logic [31:0] data1_i, data2_i, imm_i;
    logic [2:0]  ALUCtrl_i;
    logic        ALUSrc_i, RegDst_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i;
    logic [4:0]  rs_i, rt_i, rd_i;
    logic        exmem_RegWrite_i, memwb_RegWrite_i;
    logic [4:0]  exmem_rd_i, memwb_rd_i;
    logic [31:0] exmem_data_i, memwb_data_i;
    logic        valid_o;
    logic [31:0] data1_o, data2_o, store_data_o;
    logic [2:0]  ALUCtrl_o;
    logic        RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o;
    logic [4:0]  wreg_o, rs_o, rt_o;

    id_ex_stage dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .data1_i(data1_i), .data2_i(data2_i), .imm_i(imm_i), .ALUCtrl_i(ALUCtrl_i),
        .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .RegWrite_i(RegWrite_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .MemtoReg_i(MemtoReg_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
        .exmem_RegWrite_i(exmem_RegWrite_i), .memwb_RegWrite_i(memwb_RegWrite_i),
        .exmem_rd_i(exmem_rd_i), .memwb_rd_i(memwb_rd_i),
        .exmem_data_i(exmem_data_i), .memwb_data_i(memwb_data_i),
        .valid_o(valid_o), .data1_o(data1_o), .data2_o(data2_o), .store_data_o(store_data_o),
        .ALUCtrl_o(ALUCtrl_o), .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .MemtoReg_o(MemtoReg_o), .wreg_o(wreg_o),
        .rs_o(rs_o), .rt_o(rt_o)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] data1;
        logic [31:0] data2;
        logic [31:0] store;
        logic [2:0]  alu;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic [4:0]  wreg;
        logic [4:0]  rs;
        logic [4:0]  rt;
    } out_t;

    out_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

`ifdef FWD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    function automatic out_t sample();
        out_t o;
        o = '{valid_o, data1_o, data2_o, store_data_o, ALUCtrl_o, RegWrite_o, MemRead_o,
              MemWrite_o, MemtoReg_o, wreg_o, rs_o, rt_o};
        return o;
    endfunction

    // Expected outputs for an entry captured from the current inputs, no forwarding.
    function automatic out_t model();
        out_t o;
        o.valid = valid_i;
        o.data1 = data1_i;
        o.data2 = ALUSrc_i ? imm_i : data2_i;
        o.store = data2_i;
        o.alu   = ALUCtrl_i;
        o.rw    = valid_i & RegWrite_i;
        o.mr    = valid_i & MemRead_i;
        o.mw    = valid_i & MemWrite_i;
        o.m2r   = valid_i & MemtoReg_i;
        o.wreg  = RegDst_i ? rd_i : rt_i;
        o.rs    = rs_i;
        o.rt    = rt_i;
        return o;
    endfunction

    task automatic idle_inputs();
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
        data1_i = '0; data2_i = '0; imm_i = '0; ALUCtrl_i = '0;
        ALUSrc_i = 1'b0; RegDst_i = 1'b0; RegWrite_i = 1'b0; MemRead_i = 1'b0;
        MemWrite_i = 1'b0; MemtoReg_i = 1'b0; rs_i = '0; rt_i = '0; rd_i = '0;
        exmem_RegWrite_i = 1'b0; memwb_RegWrite_i = 1'b0; exmem_rd_i = '0; memwb_rd_i = '0;
        exmem_data_i = '0; memwb_data_i = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        out_t got, e;
        idle_inputs();
        rst_i = 1'b0; valid_i = 1'b1; data1_i = 32'hDEAD; data2_i = 32'hBEEF;
        imm_i = 32'h1234; ALUSrc_i = 1'b1; ALUCtrl_i = 3'd5; RegWrite_i = 1'b1;
        MemWrite_i = 1'b1; rs_i = 5'd9; rt_i = 5'd10; rd_i = 5'd11; RegDst_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('0);
            step();
            got = sample(); e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL reset[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_load();
        out_t got, e;
        idle_inputs();
        valid_i = 1'b1; data1_i = 32'd5; data2_i = 32'd7; ALUCtrl_i = 3'b010;
        RegDst_i = 1'b1; rd_i = 5'd3; rt_i = 5'd2; rs_i = 5'd1; RegWrite_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin ALUSrc_i = 1'b1; imm_i = 32'hFFFF_FFFC; end
            if (i == 2) begin RegDst_i = 1'b0; MemRead_i = 1'b1; MemtoReg_i = 1'b1; end
            if (i == 3) begin valid_i = 1'b0; MemWrite_i = 1'b1; end
            exp_q.push_back(model());
            step();
            got = sample(); e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL load[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_stall_flush();
        out_t got, e, a;
        idle_inputs();
        valid_i = 1'b1; data1_i = 32'hA1; data2_i = 32'hA2; ALUCtrl_i = 3'd6;
        RegWrite_i = 1'b1; MemWrite_i = 1'b1; rs_i = 5'd7; rt_i = 5'd8; rd_i = 5'd9;
        RegDst_i = 1'b1;
        a = model();
        // i=0 loads A, i=1..3 stall with new inputs, i=4 stall+flush, i=5 reload, i=6 reset in stall
        for (int i = 0; i < 7; i++) begin
            if (i >= 1) begin
                stall_i = 1'b1; data1_i = 32'hB0 + i; data2_i = 32'hC0 + i;
                ALUCtrl_i = 3'd1; rd_i = 5'd20 + 5'(i); MemWrite_i = 1'b0;
            end
            if (i == 4) flush_i = 1'b1;
            if (i == 5) begin stall_i = 1'b0; flush_i = 1'b0; end
            if (i == 6) begin stall_i = 1'b1; rst_i = 1'b0; end
            if (i == 0 || (i >= 1 && i <= 3)) exp_q.push_back(a);
            else if (i == 5) exp_q.push_back(model());
            else exp_q.push_back('0);
            step();
            got = sample(); e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL stall_flush[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_forwarding();
        out_t got, e, base;
        idle_inputs();
        valid_i = 1'b1; data1_i = 32'hAAAA; data2_i = 32'hBBBB; rs_i = 5'd4; rt_i = 5'd5;
        rd_i = 5'd12; RegDst_i = 1'b1; RegWrite_i = 1'b1; ALUCtrl_i = 3'b010;
        base = model();
        step();
        stall_i = 1'b1;
        exmem_rd_i = 5'd4; exmem_data_i = 32'h11; memwb_rd_i = 5'd4; memwb_data_i = 32'h22;
        // Entry is held while forwarding sources change under it.
        for (int i = 0; i < 4; i++) begin
            e = base;
            case (i)
                0: begin exmem_RegWrite_i = 1'b1; memwb_RegWrite_i = 1'b1;
                         if (Fwd) e.data1 = 32'h11; end
                1: begin exmem_RegWrite_i = 1'b0; if (Fwd) e.data1 = 32'h22; end
                2: begin memwb_rd_i = 5'd5; exmem_RegWrite_i = 1'b1;
                         if (Fwd) begin e.data1 = 32'h11; e.data2 = 32'h22; e.store = 32'h22; end
                   end
                default: begin memwb_RegWrite_i = 1'b0; exmem_rd_i = 5'd3; end
            endcase
            exp_q.push_back(e);
            if (i == 0) step(); else #2;
            got = sample(); e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL fwd[%0d] got=%h exp=%h", i, got, e);
            end
        end
        // r0 is never forwarded even when sources target it.
        stall_i = 1'b0; rs_i = 5'd0; data1_i = 32'h3333;
        exmem_RegWrite_i = 1'b1; exmem_rd_i = 5'd0; memwb_RegWrite_i = 1'b1; memwb_rd_i = 5'd0;
        exp_q.push_back(model());
        step();
        got = sample(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL fwd_r0 got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_store();
        out_t got, e;
        idle_inputs();
        valid_i = 1'b1; MemWrite_i = 1'b1; ALUSrc_i = 1'b1; imm_i = 32'h40;
        rt_i = 5'd6; rs_i = 5'd2; data1_i = 32'h1000; data2_i = 32'h55; ALUCtrl_i = 3'b010;
        memwb_RegWrite_i = 1'b1; memwb_rd_i = 5'd6; memwb_data_i = 32'h99;
        e = model();
        if (Fwd) e.store = 32'h99;
        exp_q.push_back(e);
        step();
        got = sample(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin
            n_err++;
            $display("FAIL store got=%h exp=%h", got, e);
        end
    endtask

    task automatic test_back_to_back();
        out_t got, e;
        idle_inputs();
        for (int i = 0; i < 12; i++) begin
            valid_i = 1'($urandom_range(0, 1)); data1_i = $urandom; data2_i = $urandom;
            imm_i = $urandom; ALUCtrl_i = 3'($urandom); ALUSrc_i = 1'($urandom);
            RegDst_i = 1'($urandom); RegWrite_i = 1'($urandom); MemRead_i = 1'($urandom);
            MemWrite_i = 1'($urandom); MemtoReg_i = 1'($urandom);
            rs_i = 5'($urandom); rt_i = 5'($urandom); rd_i = 5'($urandom);
            exp_q.push_back(model());
            step();
            got = sample(); e = exp_q.pop_front(); n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL b2b[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load();
        test_stall_flush();
        test_forwarding();
        test_store();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
